lab7soc_usb_rst_ctl: RTL and testbench



---
 rtl/lab7soc_usb_pkg.sv | 15 +
 rtl/lab7soc_usb_rst_ctl_if.sv | 27 ++
 rtl/lab7soc_usb_rst_pulse_timer.sv | 39 +++
 rtl/lab7soc_usb_rst_ctl.sv | 136 +++++++++++++
 tb/tb_lab7soc_usb_rst_ctl.sv | 329 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lab7soc_usb_pkg.sv
// Shared definitions for the lab7soc USB PIO slaves.
// Register map offsets and the reset-pulse FSM state type.
package lab7soc_usb_pkg;

    localparam logic [1:0] ADDR_DATA = 2'd0;
    localparam logic [1:0] ADDR_LEN  = 2'd1;
    localparam logic [1:0] ADDR_CTRL = 2'd2;
    localparam logic [1:0] ADDR_CLR  = 2'd3;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_PULSE = 1'b1
    } state_t;

endpackage

// File: rtl/lab7soc_usb_rst_ctl_if.sv
// Avalon-MM slave bus bundle for the USB reset control port.
// The master drives the transfer; the slave returns registered read data.
interface lab7soc_usb_rst_ctl_if;

    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );

endinterface

// File: rtl/lab7soc_usb_rst_pulse_timer.sv
// Loadable down-counter that times the USB reset pulse.
// last flags the final cycle of the pulse (count == 1).
module lab7soc_usb_rst_pulse_timer #(
    parameter int PULSE_W = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic [PULSE_W-1:0] len,
    output logic [PULSE_W-1:0] count,
    output logic               last
);

    logic [PULSE_W-1:0] count_q;
    logic [PULSE_W-1:0] count_d;

    // Load on start, otherwise count down and rest at zero.
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = len;
        end else if (count_q != '0) begin
            count_d = count_q - PULSE_W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
    assign last  = (count_q == PULSE_W'(1));

endmodule

// File: rtl/lab7soc_usb_rst_ctl.sv
// Avalon-MM output port driving the MAX3421E reset line.
// Software sets the level directly or fires a hardware-timed pulse.
module lab7soc_usb_rst_ctl
    import lab7soc_usb_pkg::*;
#(
    parameter int               PULSE_W     = 16,
    parameter logic             RESET_LVL   = 1'b1,
    parameter logic             ASSERT_LVL  = 1'b0,
    parameter logic [PULSE_W-1:0] DEFAULT_LEN = PULSE_W'(1000)
) (
    input  logic                 clk,
    input  logic                 reset,
    lab7soc_usb_rst_ctl_if.slave bus,
    output logic                 out_port
);

    logic               wr;
    logic               start;
    logic               clr;
    logic               load;
    logic               last;
    logic [PULSE_W-1:0] count;

    logic               data_q;
    logic               data_d;
    logic [PULSE_W-1:0] len_q;
    logic [PULSE_W-1:0] len_d;
    logic [31:0]        rdata_q;
    logic [31:0]        rdata_d;

    state_t             state_q;
    logic               busy_q;
    logic               done_q;
    logic               out_q;

    logic               unused_wd;

    assign wr        = bus.chipselect & ~bus.write_n;
    assign unused_wd = ^bus.writedata[31:PULSE_W];

    // Write decode: register next values and one-cycle strobes.
    always_comb begin
        data_d = data_q;
        len_d  = len_q;
        start  = 1'b0;
        clr    = 1'b0;
        if (wr) begin
            unique case (bus.address)
                ADDR_DATA: data_d = bus.writedata[0];
                ADDR_LEN:  len_d  = bus.writedata[PULSE_W-1:0];
                ADDR_CTRL: start  = bus.writedata[0];
                ADDR_CLR:  clr    = 1'b1;
            endcase
        end
    end

    // Only an idle start with a non-zero length arms the timer.
    assign load = (state_q == S_IDLE) && start && (len_q != '0);

    // Read mux over the pre-write register values.
    always_comb begin
        rdata_d = '0;
        unique case (bus.address)
            ADDR_DATA: rdata_d = {31'b0, data_q};
            ADDR_LEN:  rdata_d = {{(32-PULSE_W){1'b0}}, len_q};
            ADDR_CTRL: rdata_d = {30'b0, done_q, busy_q};
            ADDR_CLR:  rdata_d = {{(32-PULSE_W){1'b0}}, count};
        endcase
    end

    // Software-visible registers and registered read data.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_q  <= RESET_LVL;
            len_q   <= DEFAULT_LEN;
            rdata_q <= '0;
        end else begin
            data_q  <= data_d;
            len_q   <= len_d;
            rdata_q <= rdata_d;
        end
    end

    // Pulse FSM with registered busy/done and line level.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            out_q   <= RESET_LVL;
        end else begin
            if (clr) begin
                done_q <= 1'b0;
            end
            unique case (state_q)
                S_IDLE: begin
                    if (load) begin
                        state_q <= S_PULSE;
                        busy_q  <= 1'b1;
                        out_q   <= ASSERT_LVL;
                    end else begin
                        out_q <= data_d;
                        if (start) begin
                            done_q <= 1'b1;
                        end
                    end
                end
                S_PULSE: begin
                    if (last) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        out_q   <= data_d;
                    end else begin
                        out_q <= ASSERT_LVL;
                    end
                end
            endcase
        end
    end

    lab7soc_usb_rst_pulse_timer #(
        .PULSE_W (PULSE_W)
    ) u_timer (
        .clk   (clk),
        .reset (reset),
        .load  (load),
        .len   (len_q),
        .count (count),
        .last  (last)
    );

    assign out_port     = out_q;
    assign bus.readdata = rdata_q;

endmodule

// File: tb/tb_lab7soc_usb_rst_ctl.sv
// Randomised and directed bench for the USB reset control port.
// A cycle-level register/pulse model predicts readdata and out_port.
module tb_lab7soc_usb_rst_ctl;

    logic clk = 1'b0;
    logic reset;
    logic out_port;

    lab7soc_usb_rst_ctl_if ifc ();

    lab7soc_usb_rst_ctl dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (ifc.slave),
        .out_port (out_port)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    bit m_data;
    int m_len;
    bit m_done;
    int m_rem;

    task automatic model_reset();
        m_data = 1'b1;
        m_len  = 1000;
        m_done = 1'b0;
        m_rem  = 0;
    endtask

    function automatic logic [31:0] model_read(input logic [1:0] a);
        case (a)
            2'd0:    return {31'b0, m_data};
            2'd1:    return 32'(m_len);
            2'd2:    return {30'b0, m_done, (m_rem != 0)};
            default: return 32'(m_rem);
        endcase
    endfunction

    task automatic bus_cycle(input logic [1:0] a, input bit cs,
                             input bit wn, input logic [31:0] wd,
                             output logic [31:0] e_rd,
                             output logic e_out);
        bit wr;
        bit set;
        ifc.address    = a;
        ifc.chipselect = cs;
        ifc.write_n    = wn;
        ifc.writedata  = wd;
        wr = cs && !wn;
        @(posedge clk);
        e_rd = model_read(a);
        set  = 1'b0;
        if (m_rem > 0) begin
            m_rem--;
            if (m_rem == 0) set = 1'b1;
        end else if (wr && a == 2'd2 && wd[0]) begin
            if (m_len != 0) m_rem = m_len;
            else set = 1'b1;
        end
        if (set) m_done = 1'b1;
        else if (wr && a == 2'd3) m_done = 1'b0;
        if (wr && a == 2'd0) m_data = wd[0];
        if (wr && a == 2'd1) m_len = int'(wd[15:0]);
        e_out = (m_rem > 0) ? 1'b0 : m_data;
        #1;
    endtask

    task automatic test_reset();
        logic [31:0] e_rd;
        logic        e_out;
        logic [31:0] exp_v [4];
        exp_v[0] = 32'd1;
        exp_v[1] = 32'd1000;
        exp_v[2] = 32'd0;
        exp_v[3] = 32'd0;
        reset          = 1'b1;
        ifc.address    = 2'd0;
        ifc.chipselect = 1'b0;
        ifc.write_n    = 1'b1;
        ifc.writedata  = '0;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (out_port !== 1'b1) begin
            bad++;
            $display("FAIL rst_out got=%b exp=1", out_port);
        end
        total++;
        if (ifc.readdata !== 32'd0) begin
            bad++;
            $display("FAIL rst_rd got=%h exp=0", ifc.readdata);
        end
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        for (int i = 0; i < 4; i++) begin
            bus_cycle(2'(i), 1'b1, 1'b1, '0, e_rd, e_out);
            total++;
            if (ifc.readdata !== exp_v[i]) begin
                bad++;
                $display("FAIL rst_read a=%0d got=%h exp=%h",
                         i, ifc.readdata, exp_v[i]);
            end
            total++;
            if (out_port !== 1'b1) begin
                bad++;
                $display("FAIL rst_line got=%b exp=1", out_port);
            end
        end
    endtask

    task automatic test_data();
        logic [31:0] e_rd;
        logic        e_out;
        for (int v = 0; v < 2; v++) begin
            bus_cycle(2'd0, 1'b1, 1'b0, 32'(v), e_rd, e_out);
            total++;
            if (out_port !== 1'(v)) begin
                bad++;
                $display("FAIL data_out got=%b exp=%0d", out_port, v);
            end
            bus_cycle(2'd0, 1'b1, 1'b1, '0, e_rd, e_out);
            total++;
            if (ifc.readdata !== 32'(v)) begin
                bad++;
                $display("FAIL data_rd got=%h exp=%0d", ifc.readdata, v);
            end
        end
    endtask

    task automatic test_pulse();
        logic [31:0] e_rd;
        logic        e_out;
        int          lows;
        bus_cycle(2'd1, 1'b1, 1'b0, 32'd5, e_rd, e_out);
        bus_cycle(2'd2, 1'b1, 1'b0, 32'd1, e_rd, e_out);
        lows = (out_port === 1'b0) ? 1 : 0;
        for (int i = 0; i < 8; i++) begin
            bus_cycle(2'd2, 1'b1, 1'b1, '0, e_rd, e_out);
            if (out_port === 1'b0) lows++;
            total++;
            if (ifc.readdata !== e_rd || out_port !== e_out) begin
                bad++;
                $display("FAIL pulse_cyc i=%0d rd=%h/%h out=%b/%b",
                         i, ifc.readdata, e_rd, out_port, e_out);
            end
            if (i == 1) begin
                total++;
                if (ifc.readdata[0] !== 1'b1) begin
                    bad++;
                    $display("FAIL pulse_busy got=%h exp=1", ifc.readdata);
                end
            end
        end
        total++;
        if (lows != 5) begin
            bad++;
            $display("FAIL pulse_len got=%0d exp=5", lows);
        end
        total++;
        if (ifc.readdata !== 32'd2 || out_port !== 1'b1) begin
            bad++;
            $display("FAIL pulse_end rd=%h out=%b exp 2/1",
                     ifc.readdata, out_port);
        end
        bus_cycle(2'd3, 1'b1, 1'b0, '0, e_rd, e_out);
        bus_cycle(2'd2, 1'b1, 1'b1, '0, e_rd, e_out);
        total++;
        if (ifc.readdata !== 32'd0) begin
            bad++;
            $display("FAIL pulse_clr got=%h exp=0", ifc.readdata);
        end
    endtask

    task automatic test_data_in_pulse();
        logic [31:0] e_rd;
        logic        e_out;
        int          lows;
        bus_cycle(2'd1, 1'b1, 1'b0, 32'd8, e_rd, e_out);
        bus_cycle(2'd2, 1'b1, 1'b0, 32'd1, e_rd, e_out);
        lows = 1;
        for (int i = 1; i < 12; i++) begin
            if (i == 3)
                bus_cycle(2'd0, 1'b1, 1'b0, 32'd0, e_rd, e_out);
            else if (i == 4)
                bus_cycle(2'd2, 1'b1, 1'b0, 32'd1, e_rd, e_out);
            else
                bus_cycle(2'd3, 1'b1, 1'b1, '0, e_rd, e_out);
            if (m_rem > 0) lows++;
            total++;
            if (ifc.readdata !== e_rd || out_port !== e_out) begin
                bad++;
                $display("FAIL dip_cyc i=%0d rd=%h/%h out=%b/%b",
                         i, ifc.readdata, e_rd, out_port, e_out);
            end
        end
        total++;
        if (lows != 8 || out_port !== 1'b0) begin
            bad++;
            $display("FAIL dip_end lows=%0d out=%b exp 8/0",
                     lows, out_port);
        end
        bus_cycle(2'd0, 1'b1, 1'b0, 32'd1, e_rd, e_out);
        bus_cycle(2'd3, 1'b1, 1'b0, '0, e_rd, e_out);
    endtask

    task automatic test_zero_len();
        logic [31:0] e_rd;
        logic        e_out;
        bus_cycle(2'd1, 1'b1, 1'b0, 32'd0, e_rd, e_out);
        bus_cycle(2'd2, 1'b1, 1'b0, 32'd1, e_rd, e_out);
        total++;
        if (out_port !== 1'b1) begin
            bad++;
            $display("FAIL zl_out got=%b exp=1", out_port);
        end
        bus_cycle(2'd2, 1'b1, 1'b1, '0, e_rd, e_out);
        total++;
        if (ifc.readdata !== 32'd2 || out_port !== 1'b1) begin
            bad++;
            $display("FAIL zl_stat rd=%h out=%b exp 2/1",
                     ifc.readdata, out_port);
        end
        bus_cycle(2'd3, 1'b1, 1'b0, '0, e_rd, e_out);
    endtask

    task automatic test_clear_collision();
        logic [31:0] e_rd;
        logic        e_out;
        bus_cycle(2'd1, 1'b1, 1'b0, 32'd3, e_rd, e_out);
        bus_cycle(2'd2, 1'b1, 1'b0, 32'd1, e_rd, e_out);
        bus_cycle(2'd2, 1'b1, 1'b1, '0, e_rd, e_out);
        bus_cycle(2'd2, 1'b1, 1'b1, '0, e_rd, e_out);
        bus_cycle(2'd3, 1'b1, 1'b0, '0, e_rd, e_out);
        total++;
        if (out_port !== 1'b1) begin
            bad++;
            $display("FAIL cc_out got=%b exp=1", out_port);
        end
        bus_cycle(2'd2, 1'b1, 1'b1, '0, e_rd, e_out);
        total++;
        if (ifc.readdata !== 32'd2) begin
            bad++;
            $display("FAIL cc_done got=%h exp=2", ifc.readdata);
        end
        bus_cycle(2'd3, 1'b1, 1'b0, '0, e_rd, e_out);
    endtask

    task automatic test_reset_mid_pulse();
        logic [31:0] e_rd;
        logic        e_out;
        bus_cycle(2'd1, 1'b1, 1'b0, 32'd10, e_rd, e_out);
        bus_cycle(2'd2, 1'b1, 1'b0, 32'd1, e_rd, e_out);
        bus_cycle(2'd3, 1'b1, 1'b1, '0, e_rd, e_out);
        bus_cycle(2'd3, 1'b1, 1'b1, '0, e_rd, e_out);
        total++;
        if (out_port !== 1'b0) begin
            bad++;
            $display("FAIL rmp_pre got=%b exp=0", out_port);
        end
        #2;
        reset = 1'b1;
        #1;
        total++;
        if (out_port !== 1'b1) begin
            bad++;
            $display("FAIL rmp_async got=%b exp=1", out_port);
        end
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        bus_cycle(2'd2, 1'b1, 1'b1, '0, e_rd, e_out);
        total++;
        if (ifc.readdata !== 32'd0) begin
            bad++;
            $display("FAIL rmp_stat got=%h exp=0", ifc.readdata);
        end
        bus_cycle(2'd3, 1'b1, 1'b1, '0, e_rd, e_out);
        total++;
        if (ifc.readdata !== 32'd0 || out_port !== 1'b1) begin
            bad++;
            $display("FAIL rmp_rem rd=%h out=%b exp 0/1",
                     ifc.readdata, out_port);
        end
    endtask

    task automatic test_random();
        logic [31:0] e_rd;
        logic        e_out;
        logic [1:0]  a;
        logic [31:0] wd;
        bit          cs;
        bit          wn;
        for (int i = 0; i < 400; i++) begin
            a  = 2'($urandom_range(0, 3));
            cs = ($urandom_range(0, 3) != 0);
            wn = ($urandom_range(0, 2) != 0);
            wd = $urandom;
            if (a == 2'd1) wd[15:0] = 16'($urandom_range(0, 12));
            bus_cycle(a, cs, wn, wd, e_rd, e_out);
            total++;
            if (ifc.readdata !== e_rd || out_port !== e_out) begin
                bad++;
                $display("FAIL rand i=%0d a=%0d rd=%h/%h out=%b/%b",
                         i, a, ifc.readdata, e_rd, out_port, e_out);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_data();
        test_pulse();
        test_data_in_pulse();
        test_zero_len();
        test_clear_collision();
        test_reset_mid_pulse();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
